// File: rtl/accumulator_pkg.sv
// Shared types for the accumulator back-buffer drain path.
// Element-width codes, drain FSM states and word-width helper.
package accumulator_pkg;

    typedef enum logic [1:0] {
        BW4  = 2'd0,
        BW8  = 2'd1,
        BW16 = 2'd2
    } bw_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LAST  = 2'd2
    } drain_state_e;

    function automatic int word_width(input int sew);
        return sew * 4;
    endfunction

endpackage

// File: rtl/relu_lanes.sv
// Per-lane ReLU on one drained word (combinational).
// Each element slot is zeroed when its owning lane is negative.
module relu_lanes
    import accumulator_pkg::*;
#(
    parameter  int SEW = 4,
    localparam int WW  = word_width(SEW)
) (
    input  logic [WW-1:0] i_word,
    input  bw_e           i_bw,
    output logic [WW-1:0] o_word
);

    logic [3:0] w_neg;

    // Find the sign bit of the lane owning each slot, clear negative slots
    always_comb begin
        w_neg  = '0;
        o_word = i_word;
        for (int k = 0; k < 4; k++) begin
            case (i_bw)
                BW4:     w_neg[k] = i_word[k*SEW + SEW - 1];
                BW8:     w_neg[k] = i_word[(k/2)*2*SEW + 2*SEW - 1];
                default: w_neg[k] = i_word[WW-1];
            endcase
            if (w_neg[k]) begin
                o_word[k*SEW +: SEW] = '0;
            end
        end
    end

endmodule

// File: rtl/accumulator_drain.sv
// Back-buffer drain: walks bank/entry selects, streams words on valid/ready.
// Optional ReLU clamp enabled by macro ACCUMULATOR_DRAIN_RELU_EN.
module accumulator_drain
    import accumulator_pkg::*;
#(
    parameter  int BUFFER_WIDTH           = 8,
    parameter  int BANK_COUNT             = 256,
    parameter  int TILE_SIZE              = 256,
    parameter  int SMALLEST_ELEMENT_WIDTH = 4,
    localparam int WORD_W = word_width(SMALLEST_ELEMENT_WIDTH),
    localparam int ENT_W  = $clog2(BUFFER_WIDTH),
    localparam int BANK_W = $clog2(TILE_SIZE),
    localparam int IDX_W  = $clog2(BANK_COUNT*BUFFER_WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        bitwidth,
    output logic [ENT_W-1:0]  back_buffer_bank_entry,
    output logic [BANK_W-1:0] back_buffer_bank_read,
    input  logic [WORD_W-1:0] back_buffer_data_read,
    output logic [WORD_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ENT_W-1:0]  ENT_LAST  = ENT_W'(BUFFER_WIDTH-1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_COUNT-1);

    drain_state_e r_state;
    drain_state_e w_state_nxt;

    logic [ENT_W-1:0]  r_entry;
    logic [BANK_W-1:0] r_bank;
    logic [WORD_W-1:0] r_data;
    logic [IDX_W-1:0]  r_index;
    logic              r_last;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_load;
    logic              w_finish;
    logic              w_final;
    logic [IDX_W-1:0]  w_index;
    logic [WORD_W-1:0] w_word;

    assign w_final = (r_bank == BANK_LAST) && (r_entry == ENT_LAST);
    assign w_index = IDX_W'(r_bank) * IDX_W'(BUFFER_WIDTH)
                   + IDX_W'(r_entry);

`ifdef ACCUMULATOR_DRAIN_RELU_EN
    bw_e r_bw;

    // Capture element width at start; code 3 folds onto 16b
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bw <= BW4;
        end else if (w_accept) begin
            r_bw <= (bitwidth == 2'd3) ? BW16 : bw_e'(bitwidth);
        end
    end

    relu_lanes #(
        .SEW(SMALLEST_ELEMENT_WIDTH)
    ) u_relu (
        .i_word(back_buffer_data_read),
        .i_bw  (r_bw),
        .o_word(w_word)
    );
`else
    logic [1:0] w_unused_bw;
    assign w_unused_bw = bitwidth;
    assign w_word      = back_buffer_data_read;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and load/finish strobes; start during done is ignored
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_valid || out_ready) begin
                    w_load = 1'b1;
                    if (w_final) begin
                        w_state_nxt = LAST;
                    end
                end
            end
            LAST: begin
                if (r_valid && out_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Selects, output register and status flags
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_entry <= '0;
            r_bank  <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_entry <= '0;
                r_bank  <= '0;
                r_busy  <= 1'b1;
            end
            if (w_load) begin
                r_data  <= w_word;
                r_index <= w_index;
                r_valid <= 1'b1;
                r_last  <= w_final;
                if (r_entry == ENT_LAST) begin
                    r_entry <= '0;
                    r_bank  <= w_final ? '0 : r_bank + 1'b1;
                end else begin
                    r_entry <= r_entry + 1'b1;
                end
            end
            if (w_finish) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign back_buffer_bank_entry = r_entry;
    assign back_buffer_bank_read  = r_bank;
    assign out_data               = r_data;
    assign out_index              = r_index;
    assign out_last               = r_last;
    assign out_valid              = r_valid;
    assign busy                   = r_busy;
    assign done                   = r_done;

endmodule

// File: tb/tb_accumulator_drain.sv
// Bench for accumulator_drain with a 4-bank x 2-entry array model.
// Reference recomputes each drain as a list of expected words.
module tb_accumulator_drain;

    localparam int BWD = 2;
    localparam int BC  = 4;
    localparam int NW  = BC * BWD;
`ifdef ACCUMULATOR_DRAIN_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  bitwidth = 2'd0;
    logic        out_ready = 1'b0;
    logic [0:0]  bank_entry;
    logic [7:0]  bank_read;
    logic [15:0] data_read;
    logic [15:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        out_valid;
    logic        busy;
    logic        done;

    logic [15:0] mem [NW];

    int vecs = 0;
    int miss = 0;
    int done_cnt = 0;
    int cyc_no = 0;

    typedef struct {
        logic [15:0] d;
        int          idx;
        bit          last;
        int          t;
    } beat_t;

    beat_t got_q[$];

    typedef struct {
        logic [1:0]  bw;
        logic [15:0] word;
        logic [15:0] relu;
    } vec_t;

    vec_t tbl[9];

    accumulator_drain #(
        .BUFFER_WIDTH(BWD),
        .BANK_COUNT(BC),
        .TILE_SIZE(256),
        .SMALLEST_ELEMENT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .bitwidth(bitwidth),
        .back_buffer_bank_entry(bank_entry),
        .back_buffer_bank_read(bank_read),
        .back_buffer_data_read(data_read),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (bank_read < 8'(BC)) begin
            data_read = mem[int'(bank_read) * BWD + int'(bank_entry)];
        end else begin
            data_read = 16'hDEAD;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] relu_ref(input logic [15:0] w,
                                             input logic [1:0] bw);
        int ew;
        int e;
        logic [15:0] r;
        ew = (bw == 2'd0) ? 4 : (bw == 2'd1) ? 8 : 16;
        r = 16'h0;
        for (int l = 0; l < 16 / ew; l++) begin
            e = (int'(w) >> (l * ew)) & ((1 << ew) - 1);
            if (e < (1 << (ew - 1))) begin
                r = r | 16'(e << (l * ew));
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] expect_word(input logic [15:0] w,
                                                input logic [1:0] bw);
        return RELU_ON ? relu_ref(w, bw) : w;
    endfunction

    logic        p_stall = 1'b0;
    logic [15:0] p_d = 16'h0;
    logic [2:0]  p_i = 3'd0;
    logic        p_l = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        cyc_no++;
        if (out_valid && out_ready) begin
            b.d    = out_data;
            b.idx  = int'(out_index);
            b.last = out_last;
            b.t    = cyc_no;
            got_q.push_back(b);
        end
        if (p_stall && out_valid && reset_n) begin
            chk("stall_data", 32'(out_data), 32'(p_d));
            chk("stall_index", 32'(out_index), 32'(p_i));
            chk("stall_last", 32'(out_last), 32'(p_l));
        end
        p_stall = out_valid && !out_ready;
        p_d     = out_data;
        p_i     = out_index;
        p_l     = out_last;
        if (done) done_cnt++;
        if (busy) chk("bank_sel_range", 32'(bank_read < 8'(BC)), 32'd1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pattern();
        for (int b = 0; b < BC; b++)
            for (int e = 0; e < BWD; e++)
                mem[b*BWD + e] = 16'hB0E0 + 16'(b * 16 + e);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
    endtask

    // mode 0: ready high; 1: 1,0,0,1 pattern; 2: random
    task automatic drain(input logic [1:0] bw, input int mode,
                         input bit restarts, input bit bw_flip);
        int n;
        int d0;
        got_q.delete();
        d0 = done_cnt;
        bitwidth = bw;
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = restarts && (n == 3 || done);
            if (bw_flip) bitwidth = (n >= 2) ? 2'd2 : bw;
            cyc();
            n++;
        end
        start = 1'b0;
        chk("drain_timeout", 32'(n < 200), 32'd1);
        chk("word_count", 32'(got_q.size()), 32'(NW));
        for (int i = 0; i < got_q.size() && i < NW; i++) begin
            chk("data", 32'(got_q[i].d), 32'(expect_word(mem[i], bw)));
            chk("index", 32'(got_q[i].idx), 32'(i));
            chk("last", 32'(got_q[i].last), 32'(i == NW - 1));
        end
        if (mode == 0 && got_q.size() == NW)
            chk("throughput", 32'(got_q[NW-1].t - got_q[0].t), 32'(NW - 1));
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("valid_after_done", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("no_extra_words", 32'(got_q.size()), 32'(NW));
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        logic [15:0] exp_w;

        tbl[0] = '{2'd0, 16'h9F37, 16'h0037};
        tbl[1] = '{2'd1, 16'h80FF, 16'h0000};
        tbl[2] = '{2'd2, 16'h7FFF, 16'h7FFF};
        tbl[3] = '{2'd3, 16'h8001, 16'h0000};
        tbl[4] = '{2'd0, 16'h7777, 16'h7777};
        tbl[5] = '{2'd1, 16'h7F80, 16'h7F00};
        tbl[6] = '{2'd2, 16'hFFFF, 16'h0000};
        tbl[7] = '{2'd0, 16'h8888, 16'h0000};
        tbl[8] = '{2'd1, 16'h1234, 16'h1234};

        fill_pattern();
        reset_n = 1'b0;
        repeat (2) cyc();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_bank", 32'(bank_read), 32'd0);
        chk("rst_entry", 32'(bank_entry), 32'd0);
        reset_n = 1'b1;
        cyc();

        drain(2'd2, 0, 1'b0, 1'b0);
        drain(2'd2, 1, 1'b0, 1'b0);
        drain(2'd2, 0, 1'b1, 1'b0);
        drain(2'd2, 0, 1'b0, 1'b0);

        bitwidth = 2'd2;
        out_ready = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!(out_valid && out_index == 3'd3) && n < 20) begin
            cyc();
            n++;
        end
        chk("reach_word3", 32'(out_index), 32'd3);
        d0 = done_cnt;
        reset_n = 1'b0;
        cyc();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_last", 32'(out_last), 32'd0);
        chk("abort_index", 32'(out_index), 32'd0);
        reset_n = 1'b1;
        repeat (4) cyc();
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle_valid", 32'(out_valid), 32'd0);
        drain(2'd2, 0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < NW; k++) mem[k] = tbl[i].word;
            drain(tbl[i].bw, 0, 1'b0, 1'b0);
            exp_w = RELU_ON ? tbl[i].relu : tbl[i].word;
            chk("tbl_word",
                32'((got_q.size() > 0) ? got_q[0].d : 16'hDEAD),
                32'(exp_w));
        end

        fill_random();
        drain(2'd0, 1, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            drain(2'($urandom_range(0, 3)), 2, r[0], r[1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
